// File: rtl/shifter_arbiter.sv
// Round-robin front end that shares one combinational Shifter between the EX-stage ALU (port 0)
// and the extension unit (port 1). Define SHIFTER_ARB_ROR_EN to add two-pass rotate-right.
module shifter_arbiter #(
  parameter int DW       = 32,
  parameter int SW       = 5,
  parameter bit RR_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          REQ0_valid,
  output logic          REQ0_ready,
  input  logic [DW-1:0] REQ0_DA,
  input  logic [SW-1:0] REQ0_DB,
  input  logic [1:0]    REQ0_Func,
  input  logic          REQ0_Rot,
  output logic          RSP0_valid,
  output logic [DW-1:0] RSP0_DC,

  input  logic          REQ1_valid,
  output logic          REQ1_ready,
  input  logic [DW-1:0] REQ1_DA,
  input  logic [SW-1:0] REQ1_DB,
  input  logic [1:0]    REQ1_Func,
  input  logic          REQ1_Rot,
  output logic          RSP1_valid,
  output logic [DW-1:0] RSP1_DC,

  output logic [DW-1:0] SHT_DA,
  output logic [SW-1:0] SHT_DB,
  output logic [1:0]    SHT_Func,
  input  logic [DW-1:0] SHT_DC
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] EXEC2 = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] FN_SLL = 2'b01;
  localparam logic [1:0] FN_SRL = 2'b10;

  logic [1:0]    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          gnt_q, gnt_d;
  logic [DW-1:0] da_q, da_d;
  logic [SW-1:0] db_q, db_d;
  logic [1:0]    func_q, func_d;
  logic [DW-1:0] dc0_q, dc0_d;
  logic [DW-1:0] dc1_q, dc1_d;

  logic          grant;
  logic          grant_valid;
  logic          final_valid;
  logic [DW-1:0] final_dc;

`ifdef SHIFTER_ARB_ROR_EN
  logic          rot_q, rot_d;
  logic [DW-1:0] res_q, res_d;
  logic [SW-1:0] rot_amt;

  // DW is 2^SW, so (DW - DB) mod DW is just the SW-bit negation of DB.
  assign rot_amt = -db_q;
`else
  logic unused_rot;
  assign unused_rot = REQ0_Rot ^ REQ1_Rot;
`endif

  // When both ports are waiting, the one not served last time wins.
  always_comb begin
    grant_valid = REQ0_valid | REQ1_valid;
    if (REQ0_valid && REQ1_valid) begin
      grant = ~ptr_q;
    end else begin
      grant = REQ1_valid;
    end
  end

  always_comb begin
    REQ0_ready = rst_n && (state_q == IDLE) && grant_valid && !grant;
    REQ1_ready = rst_n && (state_q == IDLE) && grant_valid && grant;
    RSP0_valid = (state_q == RESP) && !gnt_q;
    RSP1_valid = (state_q == RESP) && gnt_q;
    RSP0_DC    = dc0_q;
    RSP1_DC    = dc1_q;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    da_d        = da_q;
    db_d        = db_q;
    func_d      = func_q;
    dc0_d       = dc0_q;
    dc1_d       = dc1_q;
`ifdef SHIFTER_ARB_ROR_EN
    rot_d       = rot_q;
    res_d       = res_q;
`endif
    SHT_DA      = '0;
    SHT_DB      = '0;
    SHT_Func    = 2'b00;
    final_valid = 1'b0;
    final_dc    = SHT_DC;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = EXEC;
          ptr_d   = grant;
          gnt_d   = grant;
          da_d    = grant ? REQ1_DA   : REQ0_DA;
          db_d    = grant ? REQ1_DB   : REQ0_DB;
          func_d  = grant ? REQ1_Func : REQ0_Func;
`ifdef SHIFTER_ARB_ROR_EN
          rot_d   = grant ? REQ1_Rot  : REQ0_Rot;
`endif
        end
      end
      EXEC: begin
        SHT_DA   = da_q;
        SHT_DB   = db_q;
        SHT_Func = func_q;
`ifdef SHIFTER_ARB_ROR_EN
        if (rot_q) begin
          SHT_Func = FN_SRL;
          res_d    = SHT_DC;
          state_d  = EXEC2;
        end else begin
          final_valid = 1'b1;
          state_d     = RESP;
        end
`else
        final_valid = 1'b1;
        state_d     = RESP;
`endif
      end
`ifdef SHIFTER_ARB_ROR_EN
      // Second rotate pass brings the bits shifted out on the right back in on the left.
      EXEC2: begin
        SHT_DA      = da_q;
        SHT_DB      = rot_amt;
        SHT_Func    = FN_SLL;
        final_dc    = SHT_DC | res_q;
        final_valid = 1'b1;
        state_d     = RESP;
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (final_valid) begin
      if (gnt_q) begin
        dc1_d = final_dc;
      end else begin
        dc0_d = final_dc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= RR_RESET;
      gnt_q   <= 1'b0;
      da_q    <= '0;
      db_q    <= '0;
      func_q  <= 2'b00;
      dc0_q   <= '0;
      dc1_q   <= '0;
`ifdef SHIFTER_ARB_ROR_EN
      rot_q   <= 1'b0;
      res_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      da_q    <= da_d;
      db_q    <= db_d;
      func_q  <= func_d;
      dc0_q   <= dc0_d;
      dc1_q   <= dc1_d;
`ifdef SHIFTER_ARB_ROR_EN
      rot_q   <= rot_d;
      res_q   <= res_d;
`endif
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: a transaction-level model of the arbiter is compared against the DUT
// every cycle while directed and random traffic is applied; a plain Shifter model closes the loop.
module tb_shifter_arbiter;

  localparam int DW       = 32;
  localparam int SW       = 5;
  localparam bit RR_RESET = 1'b1;
`ifdef SHIFTER_ARB_ROR_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          REQ0_valid, REQ0_ready, REQ0_Rot, RSP0_valid;
  logic [DW-1:0] REQ0_DA, RSP0_DC;
  logic [SW-1:0] REQ0_DB;
  logic [1:0]    REQ0_Func;
  logic          REQ1_valid, REQ1_ready, REQ1_Rot, RSP1_valid;
  logic [DW-1:0] REQ1_DA, RSP1_DC;
  logic [SW-1:0] REQ1_DB;
  logic [1:0]    REQ1_Func;
  logic [DW-1:0] SHT_DA, SHT_DC;
  logic [SW-1:0] SHT_DB;
  logic [1:0]    SHT_Func;

  int nCompared = 0;
  int nMismatched = 0;

  shifter_arbiter #(.DW(DW), .SW(SW), .RR_RESET(RR_RESET)) dut (
    .clk(clk), .rst_n(rst_n),
    .REQ0_valid(REQ0_valid), .REQ0_ready(REQ0_ready), .REQ0_DA(REQ0_DA), .REQ0_DB(REQ0_DB),
    .REQ0_Func(REQ0_Func), .REQ0_Rot(REQ0_Rot), .RSP0_valid(RSP0_valid), .RSP0_DC(RSP0_DC),
    .REQ1_valid(REQ1_valid), .REQ1_ready(REQ1_ready), .REQ1_DA(REQ1_DA), .REQ1_DB(REQ1_DB),
    .REQ1_Func(REQ1_Func), .REQ1_Rot(REQ1_Rot), .RSP1_valid(RSP1_valid), .RSP1_DC(RSP1_DC),
    .SHT_DA(SHT_DA), .SHT_DB(SHT_DB), .SHT_Func(SHT_Func), .SHT_DC(SHT_DC)
  );

  // Stand-in for the combinational Shifter the arbiter drives.
  always_comb begin
    case (SHT_Func)
      2'b01:   SHT_DC = SHT_DA << SHT_DB;
      2'b10:   SHT_DC = SHT_DA >> SHT_DB;
      2'b11:   SHT_DC = $unsigned($signed(SHT_DA) >>> SHT_DB);
      default: SHT_DC = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] da0, input logic [4:0] db0,
                               input logic [1:0] f0, input logic r0,
                               input logic v1, input logic [31:0] da1, input logic [4:0] db1,
                               input logic [1:0] f1, input logic r1);
    @(posedge clk);
    #1;
    REQ0_valid = v0; REQ0_DA = da0; REQ0_DB = db0; REQ0_Func = f0; REQ0_Rot = r0;
    REQ1_valid = v1; REQ1_DA = da1; REQ1_DB = db1; REQ1_Func = f1; REQ1_Rot = r1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Bit-by-bit reference of what a completed operation must return.
  function automatic logic [31:0] refResult(input logic [31:0] da, input int db, input logic [1:0] f,
                                            input logic rot);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (rot && ROR_EN) begin
        r[i] = da[(i + db) % 32];
      end else begin
        case (f)
          2'b01:   r[i] = (i >= db) ? da[i - db] : 1'b0;
          2'b10:   r[i] = (i + db < 32) ? da[i + db] : 1'b0;
          2'b11:   r[i] = (i + db < 32) ? da[i + db] : da[31];
          default: r[i] = 1'b0;
        endcase
      end
    end
    return r;
  endfunction

  // Transaction model: cycles since acceptance decide whether the block is free, busy or responding.
  int          mPhase = 0;
  int          mLat = 2;
  int          mGnt = 0;
  int          mPtr = int'(RR_RESET);
  logic [31:0] mRes = '0;
  logic [31:0] mDc [2] = '{32'h0, 32'h0};

  always @(negedge clk) begin
    logic eR0, eR1, eV0, eV1, quiet, rot;
    int g;
    eR0 = 0; eR1 = 0; eV0 = 0; eV1 = 0; quiet = 1; rot = 0; g = 0;
    if (!rst_n) begin
      mPhase = 0;
      mPtr = int'(RR_RESET);
      mDc[0] = '0;
      mDc[1] = '0;
    end else if (mPhase == 0) begin
      if (REQ0_valid || REQ1_valid) begin
        if (REQ0_valid && REQ1_valid) g = 1 - mPtr;
        else g = REQ1_valid ? 1 : 0;
        if (g == 0) begin
          eR0 = 1;
          rot = REQ0_Rot;
          mRes = refResult(REQ0_DA, int'(REQ0_DB), REQ0_Func, REQ0_Rot);
        end else begin
          eR1 = 1;
          rot = REQ1_Rot;
          mRes = refResult(REQ1_DA, int'(REQ1_DB), REQ1_Func, REQ1_Rot);
        end
        mLat = (ROR_EN && rot) ? 3 : 2;
        mGnt = g;
        mPtr = g;
        mPhase = 1;
      end
    end else if (mPhase < mLat) begin
      quiet = 0;
      mPhase++;
    end else begin
      mDc[mGnt] = mRes;
      if (mGnt == 0) eV0 = 1;
      else eV1 = 1;
      mPhase = 0;
    end

    checkOutput("model_ready0", REQ0_ready, eR0);
    checkOutput("model_ready1", REQ1_ready, eR1);
    checkOutput("model_rsp0_valid", RSP0_valid, eV0);
    checkOutput("model_rsp1_valid", RSP1_valid, eV1);
    checkOutput("model_rsp0_dc", RSP0_DC, mDc[0]);
    checkOutput("model_rsp1_dc", RSP1_DC, mDc[1]);
    if (quiet) begin
      checkOutput("model_sht_da", SHT_DA, 0);
      checkOutput("model_sht_db", SHT_DB, 0);
      checkOutput("model_sht_func", SHT_Func, 0);
    end
  end

  // Request on port p, check acceptance, then check the response lands exactly lat cycles later.
  task automatic directedOp(input string name, input int p, input logic [31:0] da, input logic [4:0] db,
                            input logic [1:0] f, input logic r, input int lat, input logic [31:0] expDc);
    if (p == 0) applyStimulus(1, da, db, f, r, 0, 0, 0, 0, 0);
    else applyStimulus(0, 0, 0, 0, 0, 1, da, db, f, r);
    @(negedge clk);
    checkOutput({name, "_ready"}, (p == 0) ? REQ0_ready : REQ1_ready, 1);
    for (int k = 1; k < lat; k++) begin
      idleCycle();
      @(negedge clk);
      checkOutput({name, "_early"}, RSP0_valid | RSP1_valid, 0);
    end
    idleCycle();
    @(negedge clk);
    checkOutput({name, "_rsp_valid"}, (p == 0) ? RSP0_valid : RSP1_valid, 1);
    checkOutput({name, "_other_valid"}, (p == 0) ? RSP1_valid : RSP0_valid, 0);
    checkOutput({name, "_dc"}, (p == 0) ? RSP0_DC : RSP1_DC, expDc);
  endtask

  initial begin
    rst_n = 1'b0;
    REQ0_valid = 0; REQ0_DA = 0; REQ0_DB = 0; REQ0_Func = 0; REQ0_Rot = 0;
    REQ1_valid = 0; REQ1_DA = 0; REQ1_DB = 0; REQ1_Func = 0; REQ1_Rot = 0;

    @(negedge clk);
    checkOutput("reset_ready0", REQ0_ready, 0);
    checkOutput("reset_rsp0_dc", RSP0_DC, 0);
    checkOutput("reset_sht_func", SHT_Func, 0);
    idleCycle();
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      idleCycle();
      @(negedge clk);
      checkOutput("idle_sht_func", SHT_Func, 0);
      checkOutput("idle_sht_da", SHT_DA, 0);
      checkOutput("idle_ready", {REQ0_ready, REQ1_ready}, 0);
    end

    directedOp("single_sll", 0, 32'h80000001, 5'd4, 2'b01, 1'b0, 2, 32'h00000010);
    directedOp("sra_fill", 1, 32'hF0000000, 5'd8, 2'b11, 1'b0, 2, 32'hFFF00000);
    directedOp("srl_zero", 1, 32'hF0000000, 5'd8, 2'b10, 1'b0, 2, 32'h00F00000);
    directedOp("func_zero", 0, 32'hDEADBEEF, 5'd3, 2'b00, 1'b0, 2, 32'h00000000);
`ifdef SHIFTER_ARB_ROR_EN
    directedOp("ror8", 0, 32'h12345678, 5'd8, 2'b01, 1'b1, 3, 32'h78123456);
    directedOp("ror0", 0, 32'h12345678, 5'd0, 2'b11, 1'b1, 3, 32'h12345678);
`else
    directedOp("rot_ignored", 0, 32'h12345678, 5'd8, 2'b10, 1'b1, 2, 32'h00123456);
`endif

    // Abort an operation with reset the cycle after it was accepted.
    applyStimulus(1, 32'h0000FFFF, 5'd4, 2'b01, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("abort_ready", REQ0_ready, 1);
    idleCycle();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("abort_rsp_valid", RSP0_valid, 0);
      checkOutput("abort_sht_da", SHT_DA, 0);
      checkOutput("abort_sht_func", SHT_Func, 0);
      checkOutput("abort_rsp0_dc", RSP0_DC, 0);
      if (c == 0) idleCycle();
    end
    idleCycle();
    rst_n = 1'b1;
    directedOp("after_abort", 0, 32'h0000FFFF, 5'd4, 2'b01, 1'b0, 2, 32'h000FFFF0);

    // Both ports valid straight out of reset: grants alternate starting with port 0.
    idleCycle();
    rst_n = 1'b0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1, 32'h1, 5'd1, 2'b01, 0, 1, 32'h1, 5'd1, 2'b01, 0);
      if (c == 0) rst_n = 1'b1;
      @(negedge clk);
      if (c % 3 == 0) begin
        checkOutput("rr_ready0", REQ0_ready, ((c / 3) % 2 == 0) ? 1 : 0);
        checkOutput("rr_ready1", REQ1_ready, ((c / 3) % 2 == 1) ? 1 : 0);
      end
      if (c % 3 == 2) begin
        checkOutput("rr_rsp0", RSP0_valid, ((c / 3) % 2 == 0) ? 1 : 0);
        checkOutput("rr_rsp1", RSP1_valid, ((c / 3) % 2 == 1) ? 1 : 0);
        checkOutput("rr_dc", ((c / 3) % 2 == 0) ? RSP0_DC : RSP1_DC, 32'h2);
      end
    end

    // Random traffic with occasional mid-flight resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 1), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0));
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) idleCycle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
